// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: receives a byte-stream program image (base address, word
// count, little-endian data words) and writes it word by word into the
// core's data memory through the external write port. The core is held in
// reset for the whole load and released once the image is complete.
module prog_loader #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        load_req,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);

  // The idle counter only ever needs to reach TIMEOUT_CYCLES-1: the cycle
  // that would take it to TIMEOUT_CYCLES triggers the abort instead.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ADDR,
    COUNT,
    DATA,
    WRITE,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_byte_cnt;   // byte position inside the current field
  logic [31:0]     r_addr;       // address of the next word to write
  logic [15:0]     r_count;      // words still to be written
  logic [23:0]     r_word;       // low three bytes of the word being built
  logic [TW-1:0]   r_to_cnt;     // idle cycles since the last transfer
  logic            r_load_err;
  logic [31:0]     r_ext_adr;
  logic [31:0]     r_ext_wdata;

  logic            w_byte_ready;
  logic            w_xfer;
  logic            w_active;
  logic            w_timeout;
  logic            w_mem_write;

  // Bytes are accepted only in the receiving states, never while in reset.
  assign w_byte_ready = !reset &&
                        (r_state == ADDR || r_state == COUNT || r_state == DATA);
  assign w_xfer       = byte_valid && w_byte_ready;

  // A packet is in flight once its first byte has been taken; before that
  // (ADDR with nothing received) and in DONE the idle counter stays at 0.
  assign w_active  = (r_state != DONE) && !(r_state == ADDR && r_byte_cnt == 2'd0);
  assign w_timeout = w_active && !w_xfer && (r_to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ADDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the write strobe.
  always_comb begin
    w_state_next = r_state;
    w_mem_write  = 1'b0;
    case (r_state)
      ADDR: begin
        if (w_xfer && r_byte_cnt == 2'd3) w_state_next = COUNT;
      end
      COUNT: begin
        if (w_xfer && r_byte_cnt[0]) begin
          // An empty image goes straight to DONE with no writes.
          w_state_next = ({byte_data, r_count[7:0]} != 16'd0) ? DATA : DONE;
        end
      end
      DATA: begin
        if (w_xfer && r_byte_cnt == 2'd3) w_state_next = WRITE;
      end
      WRITE: begin
        w_mem_write  = 1'b1;
        w_state_next = (r_count == 16'd1) ? DONE : DATA;
      end
      DONE: begin
        if (load_req) w_state_next = ADDR;
      end
      default: w_state_next = ADDR;
    endcase
    if (w_timeout) w_state_next = ADDR;
  end

  // Field assembly, address/count bookkeeping, idle timer and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt  <= 2'd0;
      r_addr      <= 32'd0;
      r_count     <= 16'd0;
      r_word      <= 24'd0;
      r_to_cnt    <= '0;
      r_load_err  <= 1'b0;
      r_ext_adr   <= 32'd0;
      r_ext_wdata <= 32'd0;
    end else if (w_timeout) begin
      // Drop any partially received field; completed writes stay in memory.
      r_byte_cnt <= 2'd0;
      r_word     <= 24'd0;
      r_to_cnt   <= '0;
      r_load_err <= 1'b1;
    end else begin
      if (w_xfer || !w_active) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_xfer) begin
        case (r_state)
          ADDR: begin
            case (r_byte_cnt)
              2'd0: begin
                r_addr[7:0] <= {byte_data[7:2], 2'b00};  // keep word alignment
                r_load_err  <= 1'b0;                     // a fresh header starts
              end
              2'd1:    r_addr[15:8]  <= byte_data;
              2'd2:    r_addr[23:16] <= byte_data;
              default: r_addr[31:24] <= byte_data;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          COUNT: begin
            if (r_byte_cnt[0]) begin
              r_count[15:8] <= byte_data;
              r_byte_cnt    <= 2'd0;
            end else begin
              r_count[7:0]  <= byte_data;
              r_byte_cnt    <= 2'd1;
            end
          end
          DATA: begin
            case (r_byte_cnt)
              2'd0:    r_word[7:0]   <= byte_data;
              2'd1:    r_word[15:8]  <= byte_data;
              2'd2:    r_word[23:16] <= byte_data;
              default: begin
                // Last byte: present the finished word on the write port now
                // so it is valid during the single WRITE cycle that follows.
                r_ext_adr   <= r_addr;
                r_ext_wdata <= {byte_data, r_word};
              end
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          default: ;
        endcase
      end

      if (r_state == WRITE) begin
        r_addr  <= r_addr + 32'd4;   // wraps naturally at 2^32
        r_count <= r_count - 16'd1;
      end
    end
  end

  assign byte_ready    = w_byte_ready;
  assign Ext_MemWrite  = w_mem_write;
  assign Ext_WriteData = r_ext_wdata;
  assign Ext_DataAdr   = r_ext_adr;
  assign core_reset    = (r_state != DONE);
  assign load_done     = (r_state == DONE);
  assign load_err      = r_load_err;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the idle-byte cycles allowed mid-packet before abort.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have port byte_valid, input, 1, meaning an incoming byte is offered.
REQ-005 The block SHALL have port byte_data, input, 8, the offered byte.
REQ-006 The block SHALL have port byte_ready, output, 1, meaning the loader accepts byte_data this cycle.
REQ-007 The block SHALL have port load_req, input, 1, a pulse that re-enters load mode from DONE.
REQ-008 The block SHALL have port Ext_MemWrite, output, 1, the data-memory write strobe to the core's external port.
REQ-009 The block SHALL have port Ext_WriteData, output, 32, the write data.
REQ-010 The block SHALL have port Ext_DataAdr, output, 32, the byte address, always word-aligned.
REQ-011 The block SHALL have port core_reset, output, 1, driving the core's reset input; it is high while loading.
REQ-012 The block SHALL have port load_done, output, 1, high in DONE.
REQ-013 The block SHALL have port load_err, output, 1, a sticky flag set on timeout and cleared on the next valid header start.

Function
REQ-014 Packet format SHALL be: 4 bytes base address (LE), 2 bytes word count N (LE), then N×4 data bytes (each word LE).
REQ-015 A byte transfer SHALL occur only in a cycle where byte_valid && byte_ready are both high.
REQ-016 The FSM states SHALL be ADDR, COUNT, DATA, WRITE, DONE; the state after reset SHALL be ADDR.
REQ-017 ADDR SHALL accept 4 bytes into the base register, then go to COUNT; base[1:0] SHALL be forced to 0.
REQ-018 COUNT SHALL accept 2 bytes into N, then go to DATA if N≠0, else go to DONE.
REQ-019 DATA SHALL assemble 4 bytes into a word (first byte to [7:0]), then go to WRITE.
REQ-020 WRITE SHALL last exactly one cycle, with Ext_MemWrite=1, Ext_DataAdr=current address, Ext_WriteData=assembled word, and byte_ready=0.
REQ-021 After WRITE the address SHALL increment by 4, modulo 2^32 (wrap from 0xFFFFFFFC to 0x00000000 allowed), and N SHALL decrement by 1.
REQ-022 After WRITE the FSM SHALL go to DONE if the remaining N reaches 0, else return to DATA.
REQ-023 byte_ready SHALL be 1 in ADDR, COUNT and DATA, and 0 in WRITE and DONE.
REQ-024 Ext_MemWrite SHALL be 0 outside WRITE; Ext_WriteData and Ext_DataAdr hold their last values outside WRITE.
REQ-025 core_reset SHALL be 1 in all states except DONE, and SHALL deassert in the first cycle of DONE.
REQ-026 load_done SHALL equal (state==DONE).
REQ-027 In DONE, a load_req=1 SHALL move the FSM to ADDR next cycle, reasserting core_reset; load_req is ignored in other states.
REQ-028 Timeout: once at least one byte of a packet has been accepted and the FSM is not in DONE, a counter SHALL count cycles without a transfer.
REQ-029 On the counter reaching TIMEOUT_CYCLES, the FSM SHALL go to ADDR, partial byte and word state SHALL be discarded, and load_err SHALL be set to 1.
REQ-030 A transfer SHALL clear the timeout counter; the counter SHALL be held at 0 in ADDR before the first byte of a packet.
REQ-031 Writes already issued before a timeout SHALL NOT be retracted.
REQ-032 Each latency, from the transfer of the 4th byte of a word to the WRITE cycle, SHALL be exactly 1 cycle.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL set state=ADDR, byte counters=0, N=0, address=0, timeout counter=0, load_err=0.
REQ-034 When reset=1 at a clock edge, the block SHALL set outputs Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0, core_reset=1, load_done=0, byte_ready=0 during reset and 1 from the first cycle after.
REQ-035 Reset mid-packet, including during WRITE, SHALL abort immediately with no further Ext_MemWrite pulse.

Verification
REQ-036 Send 00 10 00 00 | 02 00 | 13 00 00 00 | 93 00 10 00 -> writes 0x00000013@0x1000 and 0x00100093@0x1004, then load_done=1 and core_reset=0.
REQ-037 Send header with N=0 (addr 0x20, count 00 00) -> no Ext_MemWrite, DONE reached on the cycle after the 6th byte.
REQ-038 Base 0xFFFFFFFC, N=2 -> writes at 0xFFFFFFFC then 0x00000000; base 0x00001003 -> first write at 0x00001000.
REQ-039 Stall 3 bytes into a word for TIMEOUT_CYCLES=16 -> load_err=1 at cycle 16, state ADDR, core_reset=1; the next full packet loads correctly and clears load_err.
REQ-040 After DONE, pulse load_req and send a new 1-word packet -> core_reset reasserts the next cycle, one write, then DONE again.
REQ-041 Assert reset during the WRITE cycle of word 2 of 3 -> Ext_MemWrite=0 the next cycle, state ADDR, no further writes.
